lc3_instr_encoder: RTL
======================

// Module: lc3_instr_encoder
// PURPOSE
//  LC-3 instruction encoder and loader: the inverse of the IR field decode / ADDR adder path.
//  Accepts opcode plus operand fields over valid/ready and packs them into a 16-bit instruction word.
//  PC-relative targets are converted to offset = target - (addr+1).
//  Writes each word to memory at an auto-incrementing address; used by the bench/boot path to load programs.
// PARAMETERS
//  ACK_TIMEOUT  15  max cycles mem_we is held in WRITE without mem_ack before abort
// PORTS
//  Clk        in   1   clock, rising edge
//  Reset_n    in   1   asynchronous, active-low reset
//  load_addr  in   1   set write address to base_addr (honoured in IDLE only)
//  base_addr  in   16  program base address
//  in_valid   in   1   instruction fields valid
//  in_ready   out  1   encoder can accept fields (1 only in IDLE)
//  in_op      in   4   opcode IR[15:12]
//  in_dr      in   3   DR/SR (ST*), or nzp for BR
//  in_sr1     in   3   SR1/BaseR
//  in_sr2     in   3   SR2 (ADD/AND with in_immf=0)
//  in_immf    in   1   ADD/AND immediate mode
//  in_imm     in   16  signed imm5/offset6, trapvect8, or absolute target (BR/LD/ST/LDI/STI/LEA/JSR)
//  clear_err  in   1   clears err/err_code
//  mem_we     out  1   memory write strobe
//  mem_addr   out  16  write address
//  mem_wdata  out  16  encoded instruction
//  mem_ack    in   1   memory write accepted
//  cur_addr   out  16  next write address
//  word_count out  16  words successfully written
//  err        out  1   sticky error flag
//  err_code   out  2   01 range, 10 illegal op, 11 ack timeout
// BEHAVIOUR
//  Reset (async, Reset_n=0): state IDLE; all outputs 0 except in_ready=1; cur_addr=0; timer=0.
//   Reset mid-WRITE drops mem_we immediately; no word counted.
//  FSM IDLE -> ENCODE -> WRITE -> IDLE.
//   IDLE: in_ready=1. load_addr wins over in_valid in the same cycle; fields are not taken that cycle.
//    Handshake in_valid&in_ready captures all fields into registers, then goes to ENCODE.
//   ENCODE (1 cycle): build word and run checks.
//    On error: set err/err_code, no write, cur_addr unchanged, go to IDLE.
//    Otherwise: register mem_wdata and mem_addr=cur_addr, go to WRITE.
//   WRITE: mem_we=1, mem_addr/mem_wdata stable until mem_ack.
//    On ack: mem_we=0 next cycle, cur_addr+=1 (FFFF wraps to 0000), word_count+=1 (wraps), go to IDLE.
//    If ACK_TIMEOUT cycles pass with no ack: err_code=11, no increment, go to IDLE.
//  Latency: handshake at cycle 0, mem_we=1 from cycle 2; ack in cycle 2 gives in_ready=1 at cycle 3.
//  mem_ack outside WRITE is ignored; load_addr outside IDLE is ignored.
//  Encoding (bits listed MSB first after op):
//   ADD/AND: dr,sr1,(immf? 1,imm[4:0] : 000,sr2). NOT: dr,sr1,111111.
//   LDR/STR: dr,sr1,imm[5:0]. JMP: 000,sr1,000000. TRAP: 0000,imm[7:0].
//   RTI: 0x8000. op 1101 is illegal (err 10).
//   BR/LD/ST/LDI/STI/LEA: dr,off[8:0]. JSR: 1,off[10:0] (JSRR not encoded here).
//  Arithmetic: off = in_imm - (cur_addr+1), mod 2^16.
//   Value fits N bits iff bits [15:N-1] are all equal.
//   Ranges: imm5 -16..15; offset6 -32..31; off9 -256..255; off11 -1024..1023.
//   trapvect: in_imm[15:8] must be 0. Any violation gives err 01.
//  err is sticky; clear_err clears it. If an error and clear_err occur in the same cycle, the error wins.
//  A later error overwrites err_code.
// TESTING
//  1. load 0x3000; ADD dr=1 sr1=2 immf=1 imm=-3 -> mem_we @0x3000 data 0x12BD; cur_addr=0x3001.
//  2. At 0x3001: BR nzp=111 target 0x2FFF -> data 0x0FFD (off=-3); word_count=2.
//  3. At 0x3002: LD target 0x3200 (off 509) -> err=1, code 01, no mem_we, cur_addr=0x3002.
//     clear_err -> err=0.
//  4. At 0x3002: JSR target 0x3402 -> data 0x4BFF. At 0x3003: JSR target 0x3404 -> err 01.
//  5. Hold mem_ack=0 -> mem_we high exactly ACK_TIMEOUT=15 cycles, then err code 11.
//     cur_addr unchanged; a stray ack afterwards is ignored.
//  6. load 0xFFFF; TRAP 0x25 -> data 0xF025 @0xFFFF, cur_addr=0x0000.
//     Reset_n=0 during next WRITE -> mem_we=0 asynchronously, all outputs at reset values.

Source files
------------

// File: rtl/lc3_instr_encoder.sv
// LC-3 instruction encoder/loader: packs opcode and operand fields into a
// 16-bit instruction word and writes it to memory at an auto-incrementing
// address, converting absolute PC-relative targets into signed offsets.
`timescale 1ns/1ps
module lc3_instr_encoder #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        load_addr,
    input  logic [15:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [2:0]  in_dr,
    input  logic [2:0]  in_sr1,
    input  logic [2:0]  in_sr2,
    input  logic        in_immf,
    input  logic [15:0] in_imm,
    input  logic        clear_err,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    output logic [15:0] cur_addr,
    output logic [15:0] word_count,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(ACK_TIMEOUT - 1);

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_WRITE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q;
    logic [2:0]         dr_q, sr1_q, sr2_q;
    logic               immf_q;
    logic signed [15:0] imm_q;
    logic [15:0]        cur_addr_q, cur_addr_d;
    logic [15:0]        word_count_q, word_count_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic [15:0]        mem_wdata_q, mem_wdata_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [TW-1:0]      timer_q, timer_d;

    logic               take;
    logic signed [15:0] off_s;
    logic [15:0]        enc_word;
    logic               rng_err, ill_err;

    // A value fits in msb+1 signed bits when bits [15:msb] are all equal.
    function automatic logic fits(input logic signed [15:0] v, input logic [3:0] msb);
        logic signed [15:0] sh;
        sh = v >>> msb;
        return (sh == 16'sd0) || (sh == -16'sd1);
    endfunction

    // load_addr has priority, so fields are only taken when it is low.
    assign take  = (state_q == S_IDLE) && in_valid && !load_addr;
    // PC-relative offset is measured from the incremented PC of this word.
    assign off_s = imm_q - $signed(cur_addr_q + 16'd1);

    // Capture operand fields on the input handshake.
    always_ff @(posedge Clk) begin
        if (take) begin
            op_q   <= in_op;
            dr_q   <= in_dr;
            sr1_q  <= in_sr1;
            sr2_q  <= in_sr2;
            immf_q <= in_immf;
            imm_q  <= in_imm;
        end
    end

    // Build the instruction word and flag range / illegal-opcode errors.
    always_comb begin
        enc_word = 16'h0000;
        rng_err  = 1'b0;
        ill_err  = 1'b0;
        case (op_q)
            OP_ADD, OP_AND: begin
                if (immf_q) begin
                    enc_word = {op_q, dr_q, sr1_q, 1'b1, imm_q[4:0]};
                    rng_err  = !fits(imm_q, 4'd4);
                end else begin
                    enc_word = {op_q, dr_q, sr1_q, 3'b000, sr2_q};
                end
            end
            OP_NOT:         enc_word = {op_q, dr_q, sr1_q, 6'b111111};
            OP_LDR, OP_STR: begin
                enc_word = {op_q, dr_q, sr1_q, imm_q[5:0]};
                rng_err  = !fits(imm_q, 4'd5);
            end
            OP_JMP:         enc_word = {op_q, 3'b000, sr1_q, 6'b000000};
            OP_TRAP: begin
                enc_word = {op_q, 4'b0000, imm_q[7:0]};
                rng_err  = |imm_q[15:8];
            end
            OP_RTI:         enc_word = 16'h8000;
            OP_RES:         ill_err  = 1'b1;
            OP_JSR: begin
                enc_word = {op_q, 1'b1, off_s[10:0]};
                rng_err  = !fits(off_s, 4'd10);
            end
            default: begin
                // BR, LD, ST, LDI, STI, LEA share the dr + off9 layout.
                enc_word = {op_q, dr_q, off_s[8:0]};
                rng_err  = !fits(off_s, 4'd8);
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (take) state_d = S_ENCODE;
            S_ENCODE: state_d = (rng_err || ill_err) ? S_IDLE : S_WRITE;
            S_WRITE:  if (mem_ack || timer_q == TLAST) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready = (state_q == S_IDLE);
        mem_we   = (state_q == S_WRITE);
    end

    // Next values for address, counters, write registers and error status.
    always_comb begin
        cur_addr_d   = cur_addr_q;
        word_count_d = word_count_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        timer_d      = timer_q;
        if (clear_err) begin
            err_d      = 1'b0;
            err_code_d = 2'b00;
        end
        case (state_q)
            S_IDLE: if (load_addr) cur_addr_d = base_addr;
            S_ENCODE: begin
                timer_d = '0;
                if (ill_err) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b10;
                end else if (rng_err) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                end else begin
                    mem_addr_d  = cur_addr_q;
                    mem_wdata_d = enc_word;
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    cur_addr_d   = cur_addr_q + 16'd1;
                    word_count_d = word_count_q + 16'd1;
                end else if (timer_q == TLAST) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b11;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath/status registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cur_addr_q   <= 16'h0000;
            word_count_q <= 16'h0000;
            mem_addr_q   <= 16'h0000;
            mem_wdata_q  <= 16'h0000;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
            timer_q      <= '0;
        end else begin
            cur_addr_q   <= cur_addr_d;
            word_count_q <= word_count_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            timer_q      <= timer_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cur_addr   = cur_addr_q;
    assign word_count = word_count_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule
